renkon_mem_img_pp: RTL and testbench

//  Double-buffered (ping-pong) image memory for the renkon conv pipeline.
//  The loader fills one bank while the compute side reads the other.

---
 rtl/renkon_mem_img_pp.sv | 107 ++++++++++
 tb/tb_renkon_mem_img_pp.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/renkon_mem_img_pp.sv
// Ping-pong image memory for the renkon conv pipeline.
// The loader fills bank[wr_sel] while compute reads bank[rd_sel]; banks are
// handed over by commit/release, and full_cnt tracks committed, unreleased banks.
module renkon_mem_img_pp #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned IMGSIZE = 12,
    parameter int unsigned LANES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [LANES-1:0]          wr_mask,
    input  logic [IMGSIZE-1:0]        wr_addr,
    input  logic [LANES*DWIDTH-1:0]   wr_data,
    input  logic                      wr_commit,
    output logic                      wr_ready,
    input  logic                      rd_en,
    input  logic [IMGSIZE-1:0]        rd_addr,
    output logic [LANES*DWIDTH-1:0]   rd_data,
    output logic                      rd_valid,
    input  logic                      rd_release,
    output logic                      rd_ready,
    output logic [1:0]                full_cnt
);

    localparam int unsigned WORD_W = LANES * DWIDTH;
    localparam int unsigned DEPTH  = 2 ** (IMGSIZE + 1);

    // Both banks live in one array; the bank select is the address MSB.
    logic [WORD_W-1:0] mem [DEPTH];

    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [1:0]        full_cnt_q, full_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;

    logic wr_acc, commit_acc, rd_acc, release_acc;

    // Acceptance is judged on the pre-edge ready flags.
    assign wr_ready    = (full_cnt_q != 2'd2);
    assign rd_ready    = (full_cnt_q != 2'd0);
    assign wr_acc      = wr_en & wr_ready;
    assign commit_acc  = wr_commit & wr_ready;
    assign rd_acc      = rd_en & rd_ready;
    assign release_acc = rd_release & rd_ready;

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full_cnt = full_cnt_q;

    // Next-state: bank pointers, occupancy count and registered read port.
    always_comb begin
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        full_cnt_d = full_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (commit_acc) begin
            wr_sel_d = ~wr_sel_q;
        end
        if (release_acc) begin
            rd_sel_d = ~rd_sel_q;
        end

        case ({commit_acc, release_acc})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase

        if (rd_acc) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[{rd_sel_q, rd_addr}];
        end
    end

    // Control and read-port state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            full_cnt_q <= 2'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            full_cnt_q <= full_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Per-lane masked write into the current write bank; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[{wr_sel_q, wr_addr}][i*DWIDTH +: DWIDTH] <= wr_data[i*DWIDTH +: DWIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_renkon_mem_img_pp.sv
// Scoreboard bench for the renkon ping-pong image memory.
module tb_renkon_mem_img_pp;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned LN = 4;
    localparam int unsigned WW = DW * LN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [LN-1:0] wr_mask = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [WW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [WW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_release = 1'b0;
    logic          rd_ready;
    logic [1:0]    full_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [WW-1:0] exp_q[$];

    renkon_mem_img_pp #(.DWIDTH(DW), .IMGSIZE(AW), .LANES(LN)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_release(rd_release), .rd_ready(rd_ready), .full_cnt(full_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    // One clock: inputs set before the call are sampled, then return to idle.
    task automatic tick();
        @(negedge clk);
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0; wr_mask = '0;
    endtask

    task automatic wr(input int addr, input logic [LN-1:0] mask, input logic [WW-1:0] data);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_mask = mask; wr_data = data;
        tick();
    endtask

    task automatic rd(input int addr, input logic [WW-1:0] exp);
        rd_en = 1'b1; rd_addr = AW'(addr);
        exp_q.push_back(exp);
        tick();
    endtask

    // Every valid read result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", {63'd0, rd_valid}, '0);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // T1 reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("t1_wr_ready", WW'(wr_ready), WW'(1));
        chk("t1_rd_ready", WW'(rd_ready), WW'(0));
        chk("t1_full",     WW'(full_cnt), WW'(0));
        chk("t1_rd_valid", WW'(rd_valid), WW'(0));
        chk("t1_rd_data",  rd_data, '0);

        // T2 fill bank0 and read back
        for (int a = 0; a < 16; a++) wr(a, 4'hF, pack(a*4, a*4+1, a*4+2, a*4+3));
        wr_commit = 1'b1; tick();
        chk("t2_full",     WW'(full_cnt), WW'(1));
        chk("t2_rd_ready", WW'(rd_ready), WW'(1));
        rd(5, pack(20, 21, 22, 23));
        tick();
        chk("t2_valid_drop", WW'(rd_valid), WW'(0));
        rd(15, pack(60, 61, 62, 63));
        tick();

        // T3 lane mask into bank1, plus words used later
        wr(3, 4'hF, pack(-1, -1, -1, -1));
        wr(3, 4'b0101, pack(7, 7, 7, 7));
        wr(0, 4'hF, pack(10, 11, 12, 13));
        wr(2, 4'hF, pack(30, 31, 32, 33));

        // T4 both banks full: writes and commits are refused
        wr_commit = 1'b1; tick();
        chk("t4_full2",     WW'(full_cnt), WW'(2));
        chk("t4_wr_ready",  WW'(wr_ready), WW'(0));
        wr(0, 4'hF, pack(99, 99, 99, 99));
        wr_commit = 1'b1; tick();
        chk("t4_full_hold", WW'(full_cnt), WW'(2));
        rd(0, pack(0, 1, 2, 3));
        // commit refused at full even with a same-cycle release
        wr_commit = 1'b1; rd_release = 1'b1; tick();
        chk("t4_cr_full", WW'(full_cnt), WW'(1));
        rd(3, pack(7, -1, 7, -1));
        rd(0, pack(10, 11, 12, 13));

        // T5 simultaneous handover; writer is on bank0, reader on bank1
        wr(2, 4'hF, pack(50, 51, 52, 53));
        wr_commit = 1'b1; rd_release = 1'b1; rd_en = 1'b1; rd_addr = AW'(2);
        exp_q.push_back(pack(30, 31, 32, 33));
        tick();
        chk("t5_full", WW'(full_cnt), WW'(1));
        rd(2, pack(50, 51, 52, 53));
        wr(9, 4'hF, pack(60, 61, 62, 63));
        wr_commit = 1'b1; tick();
        chk("t5_full2", WW'(full_cnt), WW'(2));
        rd_release = 1'b1; tick();
        rd(9, pack(60, 61, 62, 63));
        tick();
        chk("sb_drain", WW'(exp_q.size()), WW'(0));

        // T6 reset right after an accepted read kills it
        rd_en = 1'b1; rd_addr = AW'(9);
        @(posedge clk);
        #2 rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("t6_valid", WW'(rd_valid), WW'(0));
        chk("t6_full",  WW'(full_cnt), WW'(0));
        chk("t6_data",  rd_data, '0);
        @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b1; rd_addr = AW'(9); tick();
        tick();
        chk("t6_rd_ignored", WW'(rd_valid), WW'(0));
        chk("t6_rd_ready",   WW'(rd_ready), WW'(0));
        chk("t6_wr_ready",   WW'(wr_ready), WW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
